// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Forwarding select encodings, FSM states and a writer-match helper.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_RUN,
    ST_MEM_WAIT
  } hz_state_e;

  // x0 is never a real writer, so a match against it never counts
  function automatic logic wr_hit(
    input logic [4:0] rd,
    input logic       wr,
    input logic [4:0] rs
  );
    return wr && (rd != REG_ZERO) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_control_unit_forward_select.sv
// Operand forwarding select for one ID source register.
// Youngest matching writer wins: EX, then MEM, then WB.
module forward_select
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       used,
  input  logic [4:0] ex_rd,
  input  logic       ex_wr,
  input  logic [4:0] mem_rd,
  input  logic       mem_wr,
  input  logic [4:0] wb_rd,
  input  logic       wb_wr,
  output logic [1:0] sel
);

  logic live;

  assign live = used && (rs != REG_ZERO);

  always_comb begin
    sel = FWD_RF;
    if (live) begin
      if (wr_hit(ex_rd, ex_wr, rs))
        sel = FWD_EX;
      else if (wr_hit(mem_rd, mem_wr, rs))
        sel = FWD_MEM;
      else if (wr_hit(wb_rd, wb_wr, rs))
        sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall, flush and forward controller for the five-stage core.
// Tracks EX/MEM/WB writers and drives all pipeline enables.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] id_rd,
  input  logic       id_rf_enable,
  input  logic       id_load_instr,
  input  logic       id_ram_enable,
  input  logic       branch_taken,
  input  logic       ram_ready,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       cu_mux_sel,
  output logic       pc_load_en,
  output logic       ifid_load_en,
  output logic       ifid_flush,
  output logic       idex_load_en,
  output logic       exmem_load_en,
  output logic       memwb_load_en,
  output logic       mem_timeout
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT);

  logic [4:0] ex_rd;
  logic       ex_wr;
  logic       ex_ld;
  logic       ex_mem;
  logic [4:0] mem_rd;
  logic       mem_wr;
  logic       mem_mem;
  logic [4:0] wb_rd;
  logic       wb_wr;

  hz_state_e     state;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] cnt_nxt;

  logic [1:0] sel_a;
  logic [1:0] sel_b;

  logic hit_rs1;
  logic hit_rs2;
  logic load_use;
  logic freeze;
  logic flush;
  logic stall;
  logic normal;
  logic bubble;

  forward_select u_fwd_a (
    .rs     (id_rs1),
    .used   (id_rs1_used),
    .ex_rd  (ex_rd),
    .ex_wr  (ex_wr),
    .mem_rd (mem_rd),
    .mem_wr (mem_wr),
    .wb_rd  (wb_rd),
    .wb_wr  (wb_wr),
    .sel    (sel_a)
  );

  forward_select u_fwd_b (
    .rs     (id_rs2),
    .used   (id_rs2_used),
    .ex_rd  (ex_rd),
    .ex_wr  (ex_wr),
    .mem_rd (mem_rd),
    .mem_wr (mem_wr),
    .wb_rd  (wb_rd),
    .wb_wr  (wb_wr),
    .sel    (sel_b)
  );

  assign hit_rs1 = id_rs1_used && wr_hit(ex_rd, ex_wr, id_rs1);
  assign hit_rs2 = id_rs2_used && wr_hit(ex_rd, ex_wr, id_rs2);

  assign load_use = id_valid && ex_ld && (hit_rs1 || hit_rs2);

  // Mutually exclusive modes, gated by reset so the decoder stays one-hot
  assign freeze = reset_n && mem_mem && !ram_ready;
  assign flush  = reset_n && !freeze && branch_taken;
  assign stall  = reset_n && !freeze && !branch_taken && load_use;
  assign normal = reset_n && !freeze && !branch_taken && !load_use;
  assign bubble = flush || stall;

  assign fwd_a_sel = reset_n ? sel_a : FWD_RF;
  assign fwd_b_sel = reset_n ? sel_b : FWD_RF;

  always_comb begin
    cu_mux_sel    = 1'b1;
    pc_load_en    = 1'b0;
    ifid_load_en  = 1'b0;
    ifid_flush    = 1'b0;
    idex_load_en  = 1'b0;
    exmem_load_en = 1'b0;
    memwb_load_en = 1'b0;
    unique case (1'b1)
      !reset_n: begin
        cu_mux_sel = 1'b1;
      end
      freeze: begin
        cu_mux_sel = 1'b0;
      end
      flush: begin
        cu_mux_sel    = 1'b1;
        ifid_flush    = 1'b1;
        pc_load_en    = 1'b1;
        ifid_load_en  = 1'b1;
        idex_load_en  = 1'b1;
        exmem_load_en = 1'b1;
        memwb_load_en = 1'b1;
      end
      stall: begin
        cu_mux_sel    = 1'b1;
        idex_load_en  = 1'b1;
        exmem_load_en = 1'b1;
        memwb_load_en = 1'b1;
      end
      normal: begin
        cu_mux_sel    = 1'b0;
        pc_load_en    = 1'b1;
        ifid_load_en  = 1'b1;
        idex_load_en  = 1'b1;
        exmem_load_en = 1'b1;
        memwb_load_en = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_rd   <= REG_ZERO;
      ex_wr   <= 1'b0;
      ex_ld   <= 1'b0;
      ex_mem  <= 1'b0;
      mem_rd  <= REG_ZERO;
      mem_wr  <= 1'b0;
      mem_mem <= 1'b0;
      wb_rd   <= REG_ZERO;
      wb_wr   <= 1'b0;
    end else if (!freeze) begin
      wb_rd   <= mem_rd;
      wb_wr   <= mem_wr;
      mem_rd  <= ex_rd;
      mem_wr  <= ex_wr;
      mem_mem <= ex_mem;
      if (bubble || !id_valid) begin
        ex_rd  <= REG_ZERO;
        ex_wr  <= 1'b0;
        ex_ld  <= 1'b0;
        ex_mem <= 1'b0;
      end else begin
        ex_rd  <= id_rd;
        ex_wr  <= id_rf_enable;
        ex_ld  <= id_load_instr;
        ex_mem <= id_ram_enable;
      end
    end
  end

  // Saturating count of consecutive not-ready cycles for one access
  assign cnt_nxt = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (freeze) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= cnt_nxt;
            if (cnt_nxt == CNT_MAX)
              mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (!freeze) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= cnt_nxt;
            if (cnt_nxt == CNT_MAX)
              mem_timeout <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
